// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain into a 2-entry skid buffer with frame tagging
//
// Drains the dual-clock sample FIFO read port into a two-entry registered
// buffer and presents it as a valid/ready stream. Every FRAME_LEN-th accepted
// beat is tagged with m_last.
//
// Optional feature: define FIFO_RD_STATS_EN to add the underflow_cnt port and
// its saturating starvation counter.
//
// Ports:
//   rclk          in   read-domain clock
//   rrst_n        in   asynchronous active-low reset
//   rempty        in   FIFO empty flag (rclk domain)
//   rdata         in   FIFO word at read address, valid alongside rinc
//   rinc          out  FIFO pop, one word per cycle while high
//   rd_en         in   drain enable, gates new pops only
//   m_data        out  output sample (buffer head)
//   m_valid       out  m_data valid
//   m_ready       in   downstream accepts
//   m_last        out  current beat closes a frame
//   occupancy     out  buffer fill level 0..2
//   underflow_cnt out  starved-cycle count (FIFO_RD_STATS_EN only)
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 64
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [1:0]            occupancy
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [15:0]           underflow_cnt
`endif
);

   localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [1:0]            count_q, count_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  fire;
   logic                  push;

   assign m_valid   = (count_q != 2'd0);
   assign m_data    = head_q;
   assign occupancy = count_q;
   assign fire      = m_valid & m_ready;

   // A full buffer may still pop when the head leaves this cycle; the reset
   // term keeps the FIFO pointer still while rrst_n is low.
   assign rinc = rrst_n & rd_en & ~rempty & ((count_q < 2'd2) | fire);
   assign push = rinc;

   assign m_last = m_valid & (beat_q == LAST_BEAT);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = rdata;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && fire) begin
               head_d = rdata;
            end else if (push) begin
               tail_d  = rdata;
               count_d = 2'd2;
            end else if (fire) begin
               count_d = 2'd0;
            end
         end
         2'd2: begin
            // Push without fire cannot happen here: rinc is gated on fire.
            if (fire) begin
               head_d = tail_q;
               if (push) begin
                  tail_d = rdata;
               end else begin
                  count_d = 2'd1;
               end
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   always_comb begin
      beat_d = beat_q;
      if (fire) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         beat_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         beat_q  <= beat_d;
      end
   end

`ifdef FIFO_RD_STATS_EN
   logic [15:0] uf_q, uf_d;

   // Counts cycles where downstream is ready and draining is enabled but no
   // sample is available; saturates rather than wrapping.
   always_comb begin
      uf_d = uf_q;
      if (m_ready && !m_valid && rd_en && (uf_q != 16'hFFFF)) begin
         uf_d = uf_q + 16'd1;
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         uf_q <= 16'd0;
      end else begin
         uf_q <= uf_d;
      end
   end

   assign underflow_cnt = uf_q;
`endif

endmodule
